// File: rtl/axi_stripe_b_merge_pkg.sv
// Shared types for the striped-write B reassembly block: FSM states, fragment descriptor, response helpers.
package axi_stripe_b_merge_pkg;

    localparam int AXI_ID_BITS   = 6;
    localparam int MAX_CHAN_BITS = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAG,
        ST_RSP
    } stripe_b_state_e;

    typedef struct packed {
        logic [MAX_CHAN_BITS-1:0] chan;
        logic                     last;
        logic [AXI_ID_BITS-1:0]   id;
    } stripe_b_desc_t;

    // The AXI encoding is ordered by severity, so the worst response is the numeric maximum.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_stripe_b_merge_fifo.sv
// stripe_b_fifo: small synchronous FIFO buffering B responses of one memory channel.
// Registered write, combinational read head; a push becomes visible to the reader one cycle later.
module stripe_b_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage needs no reset; the pointers alone define which entries are valid.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/axi_stripe_b_merge.sv
// axi_stripe_b_merge: merges per-channel B fragments of striped DDR writes into one master B beat.
// Optional statistics counters are enabled with `define AXI_STRIPE_B_STATS_EN.
module axi_stripe_b_merge
    import axi_stripe_b_merge_pkg::*;
#(
    parameter  int N_CHAN     = 4,
    parameter  int FIFO_DEPTH = 16,
    parameter  int ID_BITS    = AXI_ID_BITS,
    localparam int CHAN_BITS  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [ID_BITS-1:0]   s_axi_bid,
    input  logic [1:0]           s_axi_bresp,
    input  logic                 s_axi_bvalid,
    output logic                 s_axi_bready,
    output logic [ID_BITS-1:0]   m_axi_bid,
    output logic [1:0]           m_axi_bresp,
    output logic                 m_axi_bvalid,
    input  logic                 m_axi_bready,
    input  logic                 mux_valid,
    output logic                 mux_ready,
    input  logic [CHAN_BITS-1:0] mux_chan,
    input  logic                 mux_last,
    input  logic [ID_BITS-1:0]   mux_id
`ifdef AXI_STRIPE_B_STATS_EN
    ,
    output logic [31:0]          stat_rsp,
    output logic [31:0]          stat_err,
    output logic [15:0]          stat_drop
`endif
);

    logic [N_CHAN-1:0] fifo_push;
    logic [N_CHAN-1:0] fifo_pop;
    logic [N_CHAN-1:0] fifo_full;
    logic [N_CHAN-1:0] fifo_empty;
    logic [1:0]        fifo_rdata [N_CHAN];

    logic              in_range;
    logic              sel_full;
    logic              head_empty;
    logic [1:0]        head_resp;

    stripe_b_state_e   state_q, state_d;
    stripe_b_desc_t    desc_q, desc_d;
    logic [1:0]        acc_q, acc_d, acc_n;
    logic [ID_BITS-1:0] bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              pop_en;
    logic              mux_open;

    // Out-of-range channel ids are swallowed so a bad beat can never stall the crossbar.
    assign in_range = (s_axi_bid < ID_BITS'(N_CHAN));

    always_comb begin
        sel_full  = 1'b0;
        fifo_push = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (s_axi_bid[CHAN_BITS-1:0] == CHAN_BITS'(i)) begin
                sel_full     = fifo_full[i];
                fifo_push[i] = s_axi_bvalid & in_range & ~fifo_full[i];
            end
        end
    end

    assign s_axi_bready = ~in_range | ~sel_full;

    for (genvar g = 0; g < N_CHAN; g++) begin : g_fifo
        stripe_b_fifo #(
            .WIDTH (2),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .aclk    (aclk),
            .aresetn (aresetn),
            .push    (fifo_push[g]),
            .wdata   (s_axi_bresp),
            .pop     (fifo_pop[g]),
            .rdata   (fifo_rdata[g]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g])
        );
    end

    always_comb begin
        head_empty = 1'b1;
        head_resp  = RESP_OKAY;
        fifo_pop   = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (desc_q.chan == MAX_CHAN_BITS'(i)) begin
                head_empty  = fifo_empty[i];
                head_resp   = fifo_rdata[i];
                fifo_pop[i] = pop_en;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        desc_d   = desc_q;
        acc_d    = acc_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        pop_en   = 1'b0;
        mux_open = 1'b0;
        acc_n    = resp_max(acc_q, head_resp);

        unique case (state_q)
            ST_IDLE: mux_open = 1'b1;
            ST_FRAG: begin
                if (!head_empty) begin
                    pop_en = 1'b1;
                    if (desc_q.last) begin
                        bresp_d = acc_n;
                        bid_d   = ID_BITS'(desc_q.id);
                        acc_d   = RESP_OKAY;
                        state_d = ST_RSP;
                    end else begin
                        acc_d    = acc_n;
                        mux_open = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_RSP: begin
                if (m_axi_bready) begin
                    mux_open = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A descriptor accepted in the same cycle keeps the pipeline at one fragment per cycle.
        if (mux_open && mux_valid) begin
            desc_d.chan = MAX_CHAN_BITS'(mux_chan);
            desc_d.last = mux_last;
            desc_d.id   = AXI_ID_BITS'(mux_id);
            state_d     = ST_FRAG;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            desc_q  <= '0;
            acc_q   <= RESP_OKAY;
            bid_q   <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            acc_q   <= acc_d;
            bid_q   <= bid_d;
            bresp_q <= bresp_d;
        end
    end

    assign mux_ready    = mux_open & aresetn;
    assign m_axi_bvalid = (state_q == ST_RSP) & aresetn;
    assign m_axi_bid    = bid_q;
    assign m_axi_bresp  = bresp_q;

`ifdef AXI_STRIPE_B_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_rsp  <= '0;
            stat_err  <= '0;
            stat_drop <= '0;
        end else begin
            if (m_axi_bvalid && m_axi_bready) begin
                if (stat_rsp != '1) stat_rsp <= stat_rsp + 1'b1;
                if (m_axi_bresp[1] && stat_err != '1) stat_err <= stat_err + 1'b1;
            end
            if (s_axi_bvalid && !in_range && stat_drop != '1) stat_drop <= stat_drop + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_stripe_b_merge.sv
// Randomized self-checking bench for axi_stripe_b_merge; the reference model reduces each write to the
// max of its fragment responses. Build with +define+AXI_STRIPE_B_STATS_EN to also check the counters.
module tb_axi_stripe_b_merge;

    localparam int N_CHAN     = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int ID_BITS    = 6;
    localparam int CHAN_BITS  = 2;

    typedef struct {
        int           chan;
        bit           last;
        logic [5:0]   id;
    } desc_t;

    typedef struct {
        logic [5:0]   bid;
        logic [1:0]   resp;
    } beat_t;

    typedef struct {
        logic [5:0]   id;
        logic [1:0]   resp;
    } rsp_t;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [ID_BITS-1:0]   s_axi_bid;
    logic [1:0]           s_axi_bresp;
    logic                 s_axi_bvalid;
    logic                 s_axi_bready;
    logic [ID_BITS-1:0]   m_axi_bid;
    logic [1:0]           m_axi_bresp;
    logic                 m_axi_bvalid;
    logic                 m_axi_bready;
    logic                 mux_valid;
    logic                 mux_ready;
    logic [CHAN_BITS-1:0] mux_chan;
    logic                 mux_last;
    logic [ID_BITS-1:0]   mux_id;
`ifdef AXI_STRIPE_B_STATS_EN
    logic [31:0]          stat_rsp;
    logic [31:0]          stat_err;
    logic [15:0]          stat_drop;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int beats_acc;

    desc_t desc_q[$];
    beat_t beat_q[$];
    rsp_t  exp_q[$];

    axi_stripe_b_merge #(
        .N_CHAN     (N_CHAN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ID_BITS    (ID_BITS)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi_bid    (s_axi_bid),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .m_axi_bid    (m_axi_bid),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .mux_valid    (mux_valid),
        .mux_ready    (mux_ready),
        .mux_chan     (mux_chan),
        .mux_last     (mux_last),
        .mux_id       (mux_id)
`ifdef AXI_STRIPE_B_STATS_EN
        ,
        .stat_rsp     (stat_rsp),
        .stat_err     (stat_err),
        .stat_drop    (stat_drop)
`endif
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [5:0] bid, input logic [1:0] resp, input int dl);
        bit hs = 1'b0;
        s_axi_bid    = bid;
        s_axi_bresp  = resp;
        s_axi_bvalid = 1'b1;
        while (!hs && cyc < dl) begin
            @(negedge aclk);
            hs = s_axi_bready;
            tick();
        end
        s_axi_bvalid = 1'b0;
        if (hs) beats_acc++;
        else    check("beat_timeout", 0, 1);
    endtask

    task automatic send_desc(input int chan, input bit last, input logic [5:0] id, input int dl);
        bit hs = 1'b0;
        mux_chan  = CHAN_BITS'(chan);
        mux_last  = last;
        mux_id    = id;
        mux_valid = 1'b1;
        while (!hs && cyc < dl) begin
            @(negedge aclk);
            hs = mux_ready;
            tick();
        end
        mux_valid = 1'b0;
        if (!hs) check("desc_timeout", 0, 1);
    endtask

    // Drives the queued descriptors and beats concurrently while the monitor scores merged responses.
    task automatic run(input int budget, input int desc_delay, input int hold, input bit rnd);
        int dl;
        dl = cyc + budget;
        fork
            begin : desc_thread
                desc_t d;
                repeat (desc_delay) tick();
                while (desc_q.size() > 0 && cyc < dl) begin
                    if (rnd) repeat ($urandom_range(0, 2)) tick();
                    d = desc_q.pop_front();
                    send_desc(d.chan, d.last, d.id, dl);
                end
            end
            begin : beat_thread
                beat_t b;
                while (beat_q.size() > 0 && cyc < dl) begin
                    if (rnd) repeat ($urandom_range(0, 2)) tick();
                    b = beat_q.pop_front();
                    send_beat(b.bid, b.resp, dl);
                end
            end
            begin : mon_thread
                rsp_t       e;
                bit         pend;
                logic [7:0] prev;
                int         hold_end;
                pend     = 1'b0;
                prev     = '0;
                hold_end = cyc + hold;
                while (exp_q.size() > 0 && cyc < dl) begin
                    m_axi_bready = (cyc < hold_end) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
                    @(negedge aclk);
                    if (pend) check("b_stable", {m_axi_bvalid, m_axi_bid, m_axi_bresp}, {1'b1, prev});
                    if (m_axi_bvalid && m_axi_bready) begin
                        e = exp_q.pop_front();
                        check("b_id", m_axi_bid, e.id);
                        check("b_resp", m_axi_bresp, e.resp);
                        pend = 1'b0;
                    end else begin
                        pend = m_axi_bvalid;
                        prev = {m_axi_bid, m_axi_bresp};
                    end
                    tick();
                end
                m_axi_bready = 1'b0;
            end
        join
        if (exp_q.size() != 0) check("rsp_missing", exp_q.size(), 0);
        desc_q.delete();
        beat_q.delete();
        exp_q.delete();
        repeat (3) begin
            @(negedge aclk);
            check("no_extra_beat", m_axi_bvalid, 0);
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        aresetn      = 1'b0;
        s_axi_bvalid = 1'b0;
        mux_valid    = 1'b0;
        m_axi_bready = 1'b0;
        repeat (n) tick();
        aresetn = 1'b1;
    endtask

    // Random batch: at most 15 fragments per channel, so the channel FIFOs can never deadlock the batch.
    task automatic build_batch();
        logic [1:0] chq [N_CHAN][$];
        int         nw, nf, c, left;
        logic [5:0] id;
        logic [1:0] r, mx;
        nw = $urandom_range(1, 5);
        for (int w = 0; w < nw; w++) begin
            nf = $urandom_range(1, 3);
            id = 6'($urandom);
            mx = 2'd0;
            for (int f = 0; f < nf; f++) begin
                c = $urandom_range(0, N_CHAN - 1);
                r = 2'($urandom);
                chq[c].push_back(r);
                desc_q.push_back('{chan: c, last: (f == nf - 1), id: id});
                if (r > mx) mx = r;
            end
            exp_q.push_back('{id: id, resp: mx});
        end
        left = desc_q.size();
        while (left > 0) begin
            if ($urandom_range(0, 7) == 0)
                beat_q.push_back('{bid: 6'($urandom_range(N_CHAN, 63)), resp: 2'($urandom)});
            do c = $urandom_range(0, N_CHAN - 1); while (chq[c].size() == 0);
            beat_q.push_back('{bid: 6'(c), resp: chq[c].pop_front()});
            left--;
        end
    endtask

    initial begin
        s_axi_bid    = '0;
        s_axi_bresp  = '0;
        s_axi_bvalid = 1'b0;
        m_axi_bready = 1'b0;
        mux_valid    = 1'b0;
        mux_chan     = '0;
        mux_last     = 1'b0;
        mux_id       = '0;
        aresetn      = 1'b0;

        repeat (2) tick();
        @(negedge aclk);
        check("rst_mux_ready_low", mux_ready, 0);
        check("rst_bvalid_low", m_axi_bvalid, 0);
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_mux_ready", mux_ready, 1);
        check("idle_bvalid", m_axi_bvalid, 0);
        check("idle_bid", m_axi_bid, 0);
        check("idle_bresp", m_axi_bresp, 0);
        check("idle_s_bready", s_axi_bready, 1);
        tick();

        // Single fragment: bvalid one cycle after the pop.
        send_beat(6'd2, 2'd0, cyc + 50);
        send_desc(2, 1'b1, 6'h05, cyc + 50);
        @(negedge aclk);
        check("t1_pop_cycle_bvalid", m_axi_bvalid, 0);
        tick();
        @(negedge aclk);
        check("t1_bvalid", m_axi_bvalid, 1);
        check("t1_bid", m_axi_bid, 6'h05);
        check("t1_bresp", m_axi_bresp, 0);
        tick();
        exp_q.push_back('{id: 6'h05, resp: 2'd0});
        run(50, 0, 0, 1'b0);

        // Four-fragment merge, worst response SLVERR.
        for (int c = 0; c < 4; c++) begin
            beat_q.push_back('{bid: 6'(c), resp: (c == 1) ? 2'd2 : 2'd0});
            desc_q.push_back('{chan: c, last: (c == 3), id: 6'h0A});
        end
        exp_q.push_back('{id: 6'h0A, resp: 2'd2});
        run(100, 0, 0, 1'b0);

        // Fragments arrive out of order relative to the descriptors.
        beat_q.push_back('{bid: 6'd3, resp: 2'd0});
        beat_q.push_back('{bid: 6'd1, resp: 2'd1});
        beat_q.push_back('{bid: 6'd0, resp: 2'd0});
        beat_q.push_back('{bid: 6'd2, resp: 2'd3});
        for (int c = 0; c < 4; c++) desc_q.push_back('{chan: c, last: (c == 3), id: 6'h1C});
        exp_q.push_back('{id: 6'h1C, resp: 2'd3});
        run(100, 0, 0, 1'b1);

        // Backpressure: 20 beats into ch1 with nothing draining for 40 cycles.
        beats_acc = 0;
        for (int i = 0; i < 20; i++) begin
            logic [1:0] r;
            r = 2'($urandom);
            beat_q.push_back('{bid: 6'd1, resp: r});
            desc_q.push_back('{chan: 1, last: 1'b1, id: 6'(i + 32)});
            exp_q.push_back('{id: 6'(i + 32), resp: r});
        end
        fork
            run(400, 41, 40, 1'b0);
            begin
                repeat (40) tick();
                @(negedge aclk);
                check("bp_beats_accepted", beats_acc, 16);
                check("bp_s_bready_low", s_axi_bready, 0);
            end
        join
        check("bp_all_beats_taken", beats_acc, 20);

        // Reset in the middle of a merge discards the partial accumulator and buffered beats.
        send_beat(6'd0, 2'd3, cyc + 50);
        send_beat(6'd1, 2'd3, cyc + 50);
        send_beat(6'd2, 2'd2, cyc + 50);
        send_desc(0, 1'b0, 6'h01, cyc + 50);
        send_desc(1, 1'b0, 6'h01, cyc + 50);
        repeat (3) tick();
        aresetn = 1'b0;
        @(negedge aclk);
        check("mid_rst_mux_ready", mux_ready, 0);
        check("mid_rst_bvalid", m_axi_bvalid, 0);
        tick();
        aresetn = 1'b1;
        beat_q.push_back('{bid: 6'd2, resp: 2'd0});
        desc_q.push_back('{chan: 2, last: 1'b1, id: 6'h11});
        exp_q.push_back('{id: 6'h11, resp: 2'd0});
        run(100, 0, 0, 1'b0);

        for (int b = 0; b < 10; b++) begin
            build_batch();
            run(800, 0, 0, 1'b1);
        end

`ifdef AXI_STRIPE_B_STATS_EN
        do_reset(2);
        @(negedge aclk);
        check("stat_rsp_rst", stat_rsp, 0);
        check("stat_err_rst", stat_err, 0);
        check("stat_drop_rst", stat_drop, 0);
        tick();
        beat_q.push_back('{bid: 6'd0, resp: 2'd0});
        beat_q.push_back('{bid: 6'd4, resp: 2'd3});
        beat_q.push_back('{bid: 6'd0, resp: 2'd3});
        beat_q.push_back('{bid: 6'd0, resp: 2'd1});
        for (int i = 0; i < 3; i++) desc_q.push_back('{chan: 0, last: 1'b1, id: 6'(i + 1)});
        exp_q.push_back('{id: 6'd1, resp: 2'd0});
        exp_q.push_back('{id: 6'd2, resp: 2'd3});
        exp_q.push_back('{id: 6'd3, resp: 2'd1});
        run(200, 0, 0, 1'b0);
        @(negedge aclk);
        check("stat_rsp", stat_rsp, 3);
        check("stat_err", stat_err, 1);
        check("stat_drop", stat_drop, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
